// File: rtl/dma_copy.sv
// Memory-to-memory word-copy engine sharing the CPU data bus as a second initiator.
// Define DMA_IRQ_EN to implement the irq_en control bit and the completion interrupt.
module dma_copy #(
   parameter int unsigned LEN_BITS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_MemWrite,
   input  logic [1:0]  cfg_address,
   input  logic [31:0] cfg_write_data,
   output logic [31:0] cfg_read_data,
   input  logic        bus_gnt,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] address,
   output logic [31:0] write_data,
   input  logic [31:0] read_data,
   output logic        busy,
   output logic        IRQ
);

   localparam int unsigned AW = 32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_WRITE  = 2'd2,
      S_FINISH = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       src_q, src_d;
   logic [AW-1:0]       dst_q, dst_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic [31:0]         buf_q, buf_d;
   logic                done_q, done_d;
   logic                irq_en_q, irq_en_d;
   logic                irq_q, irq_d;
   logic                start_c;

   assign start_c = cfg_MemWrite && (cfg_address == 2'd3) && cfg_write_data[0];

   // State and register file; reset aborts any copy in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         buf_q    <= '0;
         done_q   <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         buf_q    <= buf_d;
         done_q   <= done_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      buf_d      = buf_q;
      done_d     = done_q;
      irq_en_d   = irq_en_q;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      address    = '0;
      write_data = '0;
      busy       = (state_q == S_READ) || (state_q == S_WRITE);

      // Register port; pointer/count writes are locked out while a copy runs.
      if (cfg_MemWrite) begin
         case (cfg_address)
            2'd0: if (!busy) src_d = {cfg_write_data[31:2], 2'b00};
            2'd1: if (!busy) dst_d = {cfg_write_data[31:2], 2'b00};
            2'd2: if (!busy) len_d = cfg_write_data[LEN_BITS-1:0];
            default: begin
               if (cfg_write_data[1]) done_d = 1'b0;
`ifdef DMA_IRQ_EN
               irq_en_d = cfg_write_data[2];
`endif
            end
         endcase
      end

      case (state_q)
         S_IDLE: begin
            if (start_c) begin
               done_d  = 1'b0;
               state_d = (len_q == '0) ? S_FINISH : S_READ;
            end
         end
         S_READ: begin
            MemRead = bus_gnt;
            address = src_q;
            if (bus_gnt) begin
               buf_d   = read_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            MemWrite   = bus_gnt;
            address    = dst_q;
            write_data = buf_q;
            if (bus_gnt) begin
               src_d   = src_q + AW'(4);
               dst_d   = dst_q + AW'(4);
               len_d   = len_q - LEN_BITS'(1);
               state_d = (len_q == LEN_BITS'(1)) ? S_FINISH : S_READ;
            end
         end
         default: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase

`ifdef DMA_IRQ_EN
      irq_d = done_d & irq_en_d;
`else
      irq_en_d = 1'b0;
      irq_d    = 1'b0;
`endif
   end

   assign IRQ = irq_q;

   // Live register readback; CTRL reports irq_en, done and busy.
   always_comb begin
      cfg_read_data = '0;
      case (cfg_address)
         2'd0:    cfg_read_data = src_q;
         2'd1:    cfg_read_data = dst_q;
         2'd2:    cfg_read_data = 32'(len_q);
         default: cfg_read_data = {29'b0, irq_en_q, done_q, busy};
      endcase
   end

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: register table, copy-scenario table, reset-abort sequence.
module tb_dma_copy;

   localparam int unsigned LEN_BITS = 16;
`ifdef DMA_IRQ_EN
   localparam logic IRQ_IMPL = 1'b1;
`else
   localparam logic IRQ_IMPL = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        cfg_MemWrite;
   logic [1:0]  cfg_address;
   logic [31:0] cfg_write_data;
   logic [31:0] cfg_read_data;
   logic        bus_gnt;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        busy;
   logic        IRQ;

   dma_copy #(.LEN_BITS(LEN_BITS)) dut (
      .clk(clk), .reset(rst_n),
      .cfg_MemWrite(cfg_MemWrite), .cfg_address(cfg_address),
      .cfg_write_data(cfg_write_data), .cfg_read_data(cfg_read_data),
      .bus_gnt(bus_gnt), .MemRead(MemRead), .MemWrite(MemWrite),
      .address(address), .write_data(write_data), .read_data(read_data),
      .busy(busy), .IRQ(IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational word memory covering byte addresses modulo 0x400
   logic [31:0] mem [256];
   assign read_data = mem[address[9:2]];
   always @(posedge clk) if (MemWrite) mem[address[9:2]] <= write_data;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg_MemWrite = 1'b1; cfg_address = a; cfg_write_data = d;
      @(negedge clk);
      cfg_MemWrite = 1'b0; cfg_write_data = '0;
   endtask

   task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
      cfg_address = a;
      #1;
      d = cfg_read_data;
   endtask

   typedef struct {
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } reg_t;

   typedef struct {
      logic [31:0]       src;
      logic [31:0]       dst;
      int                len;
      bit                stall;
      logic [31:0]       ctrl;
      int                inj;
      int                exp_busy;
      logic [2:0][31:0]  w;
   } copy_t;

   function automatic copy_t mk(input logic [31:0] src, input logic [31:0] dst, input int len,
                                input bit stall, input logic [31:0] ctrl, input int inj,
                                input int exp_busy, input logic [31:0] w0,
                                input logic [31:0] w1, input logic [31:0] w2);
      copy_t c;
      c.src = src; c.dst = dst; c.len = len; c.stall = stall; c.ctrl = ctrl;
      c.inj = inj; c.exp_busy = exp_busy;
      c.w[0] = w0; c.w[1] = w1; c.w[2] = w2;
      return c;
   endfunction

   task automatic run_copy(input copy_t c);
      int          k, nbusy, viol, nrd;
      bit          finished;
      logic [31:0] rd;
      logic [7:0]  di;
      di = c.dst[9:2];
      for (int i = 0; i <= c.len; i++) mem[8'(di + 8'(i))] <= 32'hDEAD_0000 + 32'(i);
      cfg_wr(2'd0, c.src);
      cfg_wr(2'd1, c.dst);
      cfg_wr(2'd2, 32'(c.len));
      @(negedge clk);
      cfg_MemWrite = 1'b1; cfg_address = 2'd3; cfg_write_data = c.ctrl; bus_gnt = 1'b1;
      k = 0; nbusy = 0; viol = 0; nrd = 0; finished = 1'b0;
      while (!finished && k < 100) begin
         @(negedge clk);
         if (k == c.inj) begin
            cfg_MemWrite = 1'b1; cfg_address = 2'd2; cfg_write_data = 32'd9;
         end else begin
            cfg_MemWrite = 1'b0; cfg_write_data = '0;
         end
         bus_gnt = c.stall ? (k % 2 == 1) : 1'b1;
         #1;
         if (busy) begin
            nbusy++;
            if (!bus_gnt && (MemRead || MemWrite)) viol++;
            if (MemRead && MemWrite) viol++;
            if (MemRead) begin
               chk("rd_addr", address, c.src + 32'(4 * nrd));
               nrd++;
            end
         end else begin
            finished = 1'b1;
            if (MemRead || MemWrite) viol++;
         end
         k++;
      end
      cfg_MemWrite = 1'b0; cfg_write_data = '0; bus_gnt = 1'b1;
      chk("copy_timeout", 32'(finished), 32'd1);
      chk("busy_cycles", 32'(nbusy), 32'(c.exp_busy));
      chk("strobe_viol", 32'(viol), 32'd0);
      chk("read_count", 32'(nrd), 32'(c.len));
      cfg_rd(2'd3, rd);
      chk("done_in_finish", 32'(rd[1]), 32'd0);
      @(negedge clk);
      #1;
      cfg_rd(2'd3, rd);
      chk("done_set", 32'(rd[1]), 32'd1);
      chk("irq", 32'(IRQ), 32'(IRQ_IMPL & c.ctrl[2]));
      cfg_rd(2'd2, rd);
      chk("len_end", rd, 32'd0);
      cfg_rd(2'd0, rd);
      chk("src_end", rd, c.src + 32'(4 * c.len));
      cfg_rd(2'd1, rd);
      chk("dst_end", rd, c.dst + 32'(4 * c.len));
      for (int i = 0; i < c.len; i++) chk("dst_word", mem[8'(di + 8'(i))], c.w[i]);
      chk("dst_past_end", mem[8'(di + 8'(c.len))], 32'hDEAD_0000 + 32'(c.len));
   endtask

   reg_t  regs [5];
   copy_t copies [6];

   initial begin
      logic [31:0] rd;

      regs[0] = '{2'd0, 32'h0000_0103, 32'h0000_0100};
      regs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
      regs[2] = '{2'd2, 32'h0001_2345, 32'h0000_2345};
      regs[3] = '{2'd3, 32'h0000_0004, IRQ_IMPL ? 32'h4 : 32'h0};
      regs[4] = '{2'd3, 32'h0000_0000, 32'h0000_0000};

      copies[0] = mk(32'h0, 32'h100, 3, 1'b0, 32'h1, -1, 6, 32'h11, 32'h22, 32'h33);
      copies[1] = mk(32'h0, 32'h100, 3, 1'b1, 32'h3, -1, 12, 32'h11, 32'h22, 32'h33);
      copies[2] = mk(32'h200, 32'h300, 0, 1'b0, 32'h1, -1, 0, 32'h0, 32'h0, 32'h0);
      copies[3] = mk(32'hFFFF_FFFC, 32'h140, 2, 1'b0, 32'h1, -1, 4, 32'hAAAA_0001, 32'h11, 32'h0);
      copies[4] = mk(32'h0, 32'h180, 3, 1'b0, 32'h1, 2, 6, 32'h11, 32'h22, 32'h33);
      copies[5] = mk(32'h4, 32'h1A0, 1, 1'b0, 32'h5, -1, 2, 32'h22, 32'h0, 32'h0);

      rst_n = 1'b0; cfg_MemWrite = 1'b0; cfg_address = 2'd0; cfg_write_data = '0; bus_gnt = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[0] <= 32'h11; mem[1] <= 32'h22; mem[2] <= 32'h33; mem[255] <= 32'hAAAA_0001;

      // Outputs while reset is held
      #12;
      chk("rst_memread", 32'(MemRead), 32'd0);
      chk("rst_memwrite", 32'(MemWrite), 32'd0);
      chk("rst_address", address, 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_irq", 32'(IRQ), 32'd0);
      for (int a = 0; a < 4; a++) begin
         cfg_rd(2'(a), rd);
         chk("rst_reg", rd, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cfg_rd(2'd3, rd);
      chk("ctrl_after_reset", rd, 32'd0);

      foreach (regs[i]) begin
         cfg_wr(regs[i].a, regs[i].d);
         cfg_rd(regs[i].a, rd);
         chk("reg_rw", rd, regs[i].exp);
      end

      foreach (copies[i]) run_copy(copies[i]);

      // Interrupt holds until clear-done
      repeat (3) @(negedge clk);
      #1;
      chk("irq_hold", 32'(IRQ), 32'(IRQ_IMPL));
      cfg_wr(2'd3, 32'h6);
      #1;
      chk("irq_cleared", 32'(IRQ), 32'd0);
      cfg_rd(2'd3, rd);
      chk("ctrl_after_clear", rd, IRQ_IMPL ? 32'h4 : 32'h0);

      // Reset during WRITE aborts without touching the destination
      mem[112] <= 32'hDEAD_BEEF;
      cfg_wr(2'd0, 32'h0);
      cfg_wr(2'd1, 32'h1C0);
      cfg_wr(2'd2, 32'h1);
      cfg_wr(2'd3, 32'h1);
      #1;
      chk("abort_read", 32'(MemRead), 32'd1);
      @(negedge clk);
      #1;
      chk("abort_write_pre", 32'(MemWrite), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_memwrite", 32'(MemWrite), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_address", address, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_mem", mem[112], 32'hDEAD_BEEF);
      cfg_rd(2'd3, rd);
      chk("abort_ctrl", rd, 32'd0);
      cfg_rd(2'd1, rd);
      chk("abort_dst", rd, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_copy.md
# dma_copy

Memory-to-memory word-copy engine acting as a second initiator on the CPU data bus. Software programs source, destination and word count through a small register port, then starts a copy. The engine issues single-word read/write transactions with the same MemRead/MemWrite/address/write_data/read_data signalling the CPU uses. External arbitration grants it the bus only in cycles the CPU leaves free.

## Interface
- LEN_BITS, default 16: width of the word-count register, giving a maximum of 2^LEN_BITS−1 words.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- cfg_MemWrite  in  1  register-port write strobe.
- cfg_address  in  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
- cfg_write_data  in  32  register write data.
- cfg_read_data  out  32  register read data, combinational from cfg_address.
- bus_gnt  in  1  arbiter grant; a transaction completes only in a granted cycle.
- MemRead  out  1  bus read strobe.
- MemWrite  out  1  bus write strobe.
- address  out  32  bus byte address; bits [1:0] are always 0.
- write_data  out  32  bus write data.
- read_data  in  32  bus read data; valid in the same cycle as MemRead (combinational memory).
- busy  out  1  high while a copy is in progress; the arbiter uses it as the request.
- IRQ  out  1  completion interrupt (see Configuration).

## Operation
- Registers:
  - SRC[31:0] and DST[31:0]: bits [1:0] are stored as 0.
  - LEN[LEN_BITS-1:0]: number of words to copy.
  - CTRL write: bit0 start, bit1 clear-done, bit2 irq_en.
  - CTRL read: {29'b0, irq_en, done, busy}.
- Reads of SRC, DST and LEN return their live values. During a copy these are the running pointers and the remaining count.
- Writes to SRC, DST and LEN while busy are ignored. CTRL bit1 and bit2 are always writable.
- FSM states: IDLE, READ, WRITE, FINISH.
  - IDLE: a CTRL write with bit0=1 clears done. It then goes to FINISH if LEN==0, otherwise to READ.
  - READ: MemRead=bus_gnt, address=SRC. On an edge with bus_gnt=1, read_data is latched into an internal buffer and the FSM goes to WRITE. With bus_gnt=0 it stays in READ and no strobe is asserted.
  - WRITE: MemWrite=bus_gnt, address=DST, write_data=buffer. On an edge with bus_gnt=1: SRC+=4, DST+=4, LEN−=1. Next state is FINISH if the old LEN==1, otherwise READ.
  - FINISH: done is set to 1 and the FSM returns to IDLE on the next edge.
- busy=1 in READ and WRITE.
- MemRead and MemWrite are never asserted together. Both are 0 in IDLE and FINISH.
- address is 0 and write_data is 0 in IDLE and FINISH.
- Pointer arithmetic is 32-bit and wraps modulo 2^32: 0xFFFFFFFC+4 gives 0x00000000.
- Overlapping SRC/DST regions are copied strictly in ascending order with no special handling.
- A start in the same cycle as clear-done: start takes effect and done ends 0.
- A start while busy is ignored.
- When done is already 1 and FINISH sets it, done stays 1.
- reset asserted mid-copy aborts immediately. All registers, state, done and irq_en go to 0, and MemWrite drops asynchronously.

## Timing
- Reset values: MemRead=0, MemWrite=0, address=0, write_data=0, busy=0, IRQ=0, and all registers 0.
- Start latency: the CTRL write edge enters READ, so MemRead can be asserted in the next cycle.
- Each word takes 2 granted cycles. An N-word copy with continuous grant takes 2N cycles in READ/WRITE plus 1 cycle in FINISH.
- done is observable in the cycle after the FINISH edge, i.e. 2N+1 edges after the start edge.
- Stalls (bus_gnt=0) extend the current state by one cycle each. Outputs hold their values except the strobes.

## Configuration
- DMA_IRQ_EN defined:
  - irq_en is implemented.
  - IRQ = done & irq_en, registered, and stays asserted until clear-done or reset.
- DMA_IRQ_EN undefined:
  - irq_en is not implemented; CTRL bit2 reads 0 and writes to it are ignored.
  - IRQ is tied to 0. Software polls done.

## Test plan
- Reset: with reset=0 all outputs are 0. Release reset, read CTRL: returns 0x0.
- Basic copy, continuous grant: memory holds 0x11,0x22,0x33 at 0x000–0x008; program SRC=0x000, DST=0x100, LEN=3 and start. Require words 0x100–0x108 = 0x11,0x22,0x33; busy high for exactly 6 cycles; done=1 on the 7th edge; LEN reads 0.
- Stall: same copy with bus_gnt toggling 1,0 every cycle. Require no strobe in any ungranted cycle, identical final memory, and busy high for 12 cycles.
- Boundaries:
  - LEN=0 start: require no bus strobes and done=1 after 1 cycle.
  - SRC=0xFFFFFFFC with LEN=2: second read address is 0x00000000.
  - SRC written with 0x103: reads back 0x100.
- Busy protection and abort:
  - Writing LEN=9 mid-copy: ignored, and the copy count is unchanged.
  - Asserting reset mid-WRITE: MemWrite drops immediately and the destination word is not written.
- IRQ (DMA_IRQ_EN defined): set irq_en, then a 1-word copy gives IRQ=1 until a CTRL clear-done write. Without the macro, IRQ stays 0 and CTRL bit2 reads 0.
